// File: rtl/exec_sequencer_if.sv
// Command channel into the run-control sequencer: a valid/ready handshake
// carrying a 2-bit run-control opcode.
interface exec_sequencer_if;
    logic       cmdValid;
    logic       cmdReady;
    logic [1:0] cmdOp;

    modport master (
        output cmdValid,
        output cmdOp,
        input  cmdReady
    );

    modport slave (
        input  cmdValid,
        input  cmdOp,
        output cmdReady
    );
endinterface

// File: rtl/exec_sequencer.sv
// Run-control sequencer for the single-cycle RV32 datapath: gates PC update and
// architectural commit, handles run/step/halt/clear, breakpoints and system opcodes.
module exec_sequencer #(
    parameter int XLEN      = 32,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    exec_sequencer_if.slave      cmd,
    input  logic                 bpEnable,
    input  logic [XLEN-1:0]      bpAddr,
    input  logic [XLEN-1:0]      pcOut,
    input  logic [6:0]           opcode,
    output logic                 pcEnable,
    output logic                 commitEnable,
    output logic                 halted,
    output logic [1:0]           haltCause,
    output logic [CNT_WIDTH-1:0] cycles,
    output logic [CNT_WIDTH-1:0] retired
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_STEP   = 2'b10,
        ST_HALTED = 2'b11
    } state_t;

    localparam logic [1:0] OP_RUN   = 2'b00;
    localparam logic [1:0] OP_STEP  = 2'b01;
    localparam logic [1:0] OP_HALT  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [1:0] CAUSE_RESET = 2'b00;
    localparam logic [1:0] CAUSE_CMD   = 2'b01;
    localparam logic [1:0] CAUSE_BP    = 2'b10;
    localparam logic [1:0] CAUSE_SYS   = 2'b11;

    localparam logic [6:0] SYSTEM_OPCODE = 7'b1110011;

    state_t                 state_q, state_d;
    logic                   skip_bp_q, skip_bp_d;
    logic [1:0]             halt_cause_q, halt_cause_d;
    logic [CNT_WIDTH-1:0]   cycles_q, cycles_d;
    logic [CNT_WIDTH-1:0]   retired_q, retired_d;

    logic cmd_ready;
    logic cmd_fire;
    logic bp_hit;
    logic sys_op;
    logic pc_en;
    logic commit_en;

    assign cmd_ready = (state_q != ST_STEP);
    assign cmd_fire  = cmd.cmdValid & cmd_ready;
    // skip_bp lets a resume execute the very instruction it stopped on.
    assign bp_hit    = bpEnable & (pcOut == bpAddr) & ~skip_bp_q;
    assign sys_op    = (opcode == SYSTEM_OPCODE);

    always_comb begin
        state_d      = state_q;
        skip_bp_d    = skip_bp_q;
        halt_cause_d = halt_cause_q;
        cycles_d     = cycles_q;
        retired_d    = retired_q;
        pc_en        = 1'b0;
        commit_en    = 1'b0;

        case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (cmd_fire && cmd.cmdOp == OP_RUN) begin
                    state_d   = ST_RUN;
                    skip_bp_d = 1'b1;
                end else if (cmd_fire && cmd.cmdOp == OP_STEP) begin
                    state_d   = ST_STEP;
                    skip_bp_d = 1'b1;
                end
            end

            ST_RUN: begin
                cycles_d  = cycles_q + CNT_WIDTH'(1);
                skip_bp_d = 1'b0;
                if (bp_hit) begin
                    // The breakpointed instruction is held off entirely.
                    state_d      = ST_HALTED;
                    halt_cause_d = CAUSE_BP;
                end else begin
                    pc_en     = 1'b1;
                    commit_en = 1'b1;
                    retired_d = retired_q + CNT_WIDTH'(1);
                    if (sys_op) begin
                        state_d      = ST_HALTED;
                        halt_cause_d = CAUSE_SYS;
                    end else if (cmd_fire && cmd.cmdOp == OP_HALT) begin
                        state_d      = ST_HALTED;
                        halt_cause_d = CAUSE_CMD;
                    end
                end
            end

            ST_STEP: begin
                cycles_d     = cycles_q + CNT_WIDTH'(1);
                retired_d    = retired_q + CNT_WIDTH'(1);
                pc_en        = 1'b1;
                commit_en    = 1'b1;
                skip_bp_d    = 1'b0;
                state_d      = ST_HALTED;
                halt_cause_d = sys_op ? CAUSE_SYS : CAUSE_CMD;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // CLEAR wins over any increment computed above.
        if (cmd_fire && cmd.cmdOp == OP_CLEAR) begin
            cycles_d  = '0;
            retired_d = '0;
        end

        if (!reset) begin
            pc_en     = 1'b0;
            commit_en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            skip_bp_q    <= 1'b0;
            halt_cause_q <= CAUSE_RESET;
            cycles_q     <= '0;
            retired_q    <= '0;
        end else begin
            state_q      <= state_d;
            skip_bp_q    <= skip_bp_d;
            halt_cause_q <= halt_cause_d;
            cycles_q     <= cycles_d;
            retired_q    <= retired_d;
        end
    end

    assign cmd.cmdReady = cmd_ready;
    assign pcEnable     = pc_en;
    assign commitEnable = commit_en;
    assign halted       = (state_q == ST_IDLE) || (state_q == ST_HALTED);
    assign haltCause    = halt_cause_q;
    assign cycles       = cycles_q;
    assign retired      = retired_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed, table-driven bench for exec_sequencer: one record per clock cycle
// with the inputs applied and the outputs expected before the next edge.
module tb_exec_sequencer;

    localparam logic [1:0] RUN  = 2'b00;
    localparam logic [1:0] STEP = 2'b01;
    localparam logic [1:0] HALT = 2'b10;
    localparam logic [1:0] CLR  = 2'b11;

    typedef struct {
        logic        rst_n;
        logic        vld;
        logic [1:0]  op;
        logic        bpe;
        logic [31:0] bpa;
        logic [31:0] e_pc;
        logic        e_pcen;
        logic        e_cmt;
        logic        e_rdy;
        logic        e_hlt;
        logic [1:0]  e_cause;
        logic [31:0] e_cyc;
        logic [31:0] e_ret;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bpEnable;
    logic [31:0] bpAddr;
    logic [31:0] pc_model;
    logic [6:0]  opcode;
    logic        pcEnable;
    logic        commitEnable;
    logic        halted;
    logic [1:0]  haltCause;
    logic [31:0] cycles;
    logic [31:0] retired;
    logic [6:0]  prog [0:15];

    int tests_run = 0;
    int tests_failed = 0;
    vec_t vecs[$];

    exec_sequencer_if cmd_bus();

    exec_sequencer #(.XLEN(32), .CNT_WIDTH(32)) dut (
        .clk          (clk),
        .reset        (rst_n),
        .cmd          (cmd_bus),
        .bpEnable     (bpEnable),
        .bpAddr       (bpAddr),
        .pcOut        (pc_model),
        .opcode       (opcode),
        .pcEnable     (pcEnable),
        .commitEnable (commitEnable),
        .halted       (halted),
        .haltCause    (haltCause),
        .cycles       (cycles),
        .retired      (retired)
    );

    always #5 clk = ~clk;

    // Stand-in for the pc block and instruction memory.
    always @(posedge clk) begin
        if (!rst_n)        pc_model <= 32'h0;
        else if (pcEnable) pc_model <= pc_model + 32'd4;
    end
    assign opcode = prog[pc_model[5:2]];

    task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
        end
    endtask

    function automatic void add(input logic rst_n_i, input logic vld, input logic [1:0] op,
                                input logic bpe, input logic [31:0] bpa, input logic [31:0] pc,
                                input logic pcen, input logic cmt, input logic rdy, input logic hlt,
                                input logic [1:0] cause, input logic [31:0] cyc, input logic [31:0] ret);
        vec_t v;
        v.rst_n = rst_n_i; v.vld = vld; v.op = op; v.bpe = bpe; v.bpa = bpa;
        v.e_pc = pc; v.e_pcen = pcen; v.e_cmt = cmt; v.e_rdy = rdy; v.e_hlt = hlt;
        v.e_cause = cause; v.e_cyc = cyc; v.e_ret = ret;
        vecs.push_back(v);
    endfunction

    initial begin
        for (int i = 0; i < 16; i++) prog[i] = 7'h13;
        prog[5] = 7'b1110011;  // 0x14
        prog[9] = 7'b1110011;  // 0x24

        // Reset and idle
        for (int i = 0; i < 10; i++) add(1,0,RUN,0,0, 'h0,0,0,1,1,0,0,0);
        // RUN to a system opcode at 0x14
        add(1,1,RUN,0,0,  'h0, 0,0,1,1,0,0,0);
        add(1,0,RUN,0,0,  'h0, 1,1,1,0,0,0,0);
        add(1,0,RUN,0,0,  'h4, 1,1,1,0,0,1,1);
        add(1,0,RUN,0,0,  'h8, 1,1,1,0,0,2,2);
        add(1,0,RUN,0,0,  'hC, 1,1,1,0,0,3,3);
        add(1,0,RUN,0,0,  'h10,1,1,1,0,0,4,4);
        add(1,0,RUN,0,0,  'h14,1,1,1,0,0,5,5);
        add(1,0,RUN,0,0,  'h18,0,0,1,1,3,6,6);
        // Single steps; CLEAR offered during STEP is not accepted
        add(1,1,STEP,0,0, 'h18,0,0,1,1,3,6,6);
        add(1,1,CLR,0,0,  'h18,1,1,0,0,3,6,6);
        add(1,1,STEP,0,0, 'h1C,0,0,1,1,1,7,7);
        add(1,0,RUN,0,0,  'h1C,1,1,0,0,1,7,7);
        add(1,1,STEP,0,0, 'h20,0,0,1,1,1,8,8);
        add(1,0,RUN,0,0,  'h20,1,1,0,0,1,8,8);
        add(1,1,HALT,0,0, 'h24,0,0,1,1,1,9,9);
        add(1,1,STEP,0,0, 'h24,0,0,1,1,1,9,9);
        add(1,0,RUN,0,0,  'h24,1,1,0,0,1,9,9);
        add(1,1,CLR,0,0,  'h28,0,0,1,1,3,10,10);
        add(1,0,RUN,0,0,  'h28,0,0,1,1,3,0,0);
        // Reset from HALTED, then breakpoint at 0x8
        add(0,0,RUN,0,0,  'h28,0,0,1,1,3,0,0);
        add(1,1,RUN,1,8,  'h0, 0,0,1,1,0,0,0);
        add(1,0,RUN,1,8,  'h0, 1,1,1,0,0,0,0);
        add(1,0,RUN,1,8,  'h4, 1,1,1,0,0,1,1);
        add(1,0,RUN,1,8,  'h8, 0,0,1,0,0,2,2);
        add(1,1,RUN,1,8,  'h8, 0,0,1,1,2,3,2);
        add(1,0,RUN,1,8,  'h8, 1,1,1,0,2,3,2);
        add(1,0,RUN,1,8,  'hC, 1,1,1,0,2,4,3);
        add(1,0,RUN,1,8,  'h10,1,1,1,0,2,5,4);
        add(1,0,RUN,1,8,  'h14,1,1,1,0,2,6,5);
        // Breakpoint coinciding with a HALT command
        add(1,1,RUN,1,'h1C,  'h18,0,0,1,1,3,7,6);
        add(1,0,RUN,1,'h1C,  'h18,1,1,1,0,3,7,6);
        add(1,1,HALT,1,'h1C, 'h1C,0,0,1,0,3,8,7);
        // CLEAR during RUN, system opcode beats HALT, plain HALT
        add(1,1,RUN,0,0,  'h1C,0,0,1,1,2,9,7);
        add(1,0,RUN,0,0,  'h1C,1,1,1,0,2,9,7);
        add(1,1,CLR,0,0,  'h20,1,1,1,0,2,10,8);
        add(1,1,HALT,0,0, 'h24,1,1,1,0,2,0,0);
        add(1,1,RUN,0,0,  'h28,0,0,1,1,3,1,1);
        add(1,0,RUN,0,0,  'h28,1,1,1,0,3,1,1);
        add(1,1,HALT,0,0, 'h2C,1,1,1,0,3,2,2);
        add(1,1,RUN,0,0,  'h30,0,0,1,1,1,3,3);
        add(1,1,STEP,0,0, 'h30,1,1,1,0,1,3,3);
        // Reset mid-RUN
        add(0,0,RUN,0,0,  'h34,0,0,1,0,1,4,4);
        add(1,0,RUN,0,0,  'h0, 0,0,1,1,0,0,0);

        // Hand-written power-on reset sequence
        rst_n = 1'b0;
        cmd_bus.cmdValid = 1'b0;
        cmd_bus.cmdOp = RUN;
        bpEnable = 1'b0;
        bpAddr = 32'h0;
        @(posedge clk); #1;
        check("por_pcen", -1, {31'b0, pcEnable}, 32'h0);
        check("por_cmt", -1, {31'b0, commitEnable}, 32'h0);
        check("por_halted", -1, {31'b0, halted}, 32'h1);
        check("por_cause", -1, {30'b0, haltCause}, 32'h0);
        check("por_cycles", -1, cycles, 32'h0);
        check("por_retired", -1, retired, 32'h0);
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            rst_n            = vecs[i].rst_n;
            cmd_bus.cmdValid = vecs[i].vld;
            cmd_bus.cmdOp    = vecs[i].op;
            bpEnable         = vecs[i].bpe;
            bpAddr           = vecs[i].bpa;
            #1;
            check("pc", i, pc_model, vecs[i].e_pc);
            check("pcEnable", i, {31'b0, pcEnable}, {31'b0, vecs[i].e_pcen});
            check("commitEnable", i, {31'b0, commitEnable}, {31'b0, vecs[i].e_cmt});
            check("cmdReady", i, {31'b0, cmd_bus.cmdReady}, {31'b0, vecs[i].e_rdy});
            check("halted", i, {31'b0, halted}, {31'b0, vecs[i].e_hlt});
            check("haltCause", i, {30'b0, haltCause}, {30'b0, vecs[i].e_cause});
            check("cycles", i, cycles, vecs[i].e_cyc);
            check("retired", i, retired, vecs[i].e_ret);
            $display("[TB] row %0d pc=%0h pcen=%0b cmt=%0b halted=%0b cause=%0d cycles=%0d retired=%0d",
                     i, pc_model, pcEnable, commitEnable, halted, haltCause, cycles, retired);
            @(posedge clk); #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
